// File: rtl/mem_stage_if.sv
// Shared-bus port of the memory-access stage: request/grant, address strobe,
// word address/data and ready.
interface mem_stage_if;
    localparam int unsigned ADDR_W = 30;
    localparam int unsigned DATA_W = 32;

    logic              bus_req;
    logic              bus_grnt;
    logic              bus_as;
    logic              bus_rw;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wr_data;
    logic [DATA_W-1:0] bus_rd_data;
    logic              bus_rdy;

    modport master (
        output bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
        input  bus_grnt, bus_rd_data, bus_rdy
    );

    modport slave (
        input  bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
        output bus_grnt, bus_rd_data, bus_rdy
    );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: word loads/stores over the shared bus, misalign
// detection, ME/WB register. Optional bus watchdog enabled by `define MEM_TIMEOUT_EN.
module mem_stage #(
    parameter  int unsigned TIMEOUT_CYCLES = 255,
    localparam int unsigned PC_W   = 30,
    localparam int unsigned DATA_W = 32,
    localparam int unsigned OP_W   = 2,
    localparam int unsigned REG_W  = 5,
    localparam int unsigned EXP_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [OP_W-1:0]   ex_mem_op,
    input  logic [DATA_W-1:0] ex_mem_wr_data,
    input  logic [OP_W-1:0]   ex_ctrl_op,
    input  logic [REG_W-1:0]  ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [EXP_W-1:0]  ex_exp_code,
    input  logic [DATA_W-1:0] ex_out,
    mem_stage_if.master       bus,
    output logic              busy,
    output logic [PC_W-1:0]   mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [OP_W-1:0]   mem_ctrl_op,
    output logic [REG_W-1:0]  mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [EXP_W-1:0]  mem_exp_code,
    output logic [DATA_W-1:0] mem_out
);

    localparam logic [OP_W-1:0]  MEM_OP_LDW     = 2'd1;
    localparam logic [OP_W-1:0]  MEM_OP_STW     = 2'd2;
    localparam logic [EXP_W-1:0] EXP_NO_EXP     = 3'd0;
    localparam logic [EXP_W-1:0] EXP_MISS_ALIGN = 3'd4;
    localparam logic [EXP_W-1:0] EXP_BUS_ERR    = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   mem_acc;
    logic   start;
    logic   misalign;
    logic   timeout;
    logic   req_c, as_c, rw_c, busy_c;

    // A memory op only touches the bus when nothing upstream has faulted.
    assign mem_acc  = ex_en && (ex_exp_code == EXP_NO_EXP)
                      && ((ex_mem_op == MEM_OP_LDW) || (ex_mem_op == MEM_OP_STW));
    assign start    = mem_acc && (ex_out[1:0] == 2'b00);
    assign misalign = mem_acc && (ex_out[1:0] != 2'b00);

    // Address and store data come straight from EX/ME, held stable by busy.
    assign bus.bus_addr    = ex_out[DATA_W-1:2];
    assign bus.bus_wr_data = ex_mem_wr_data;
    assign bus.bus_req     = req_c;
    assign bus.bus_as      = as_c;
    assign bus.bus_rw      = rw_c;
    assign busy            = busy_c;

`ifdef MEM_TIMEOUT_EN
    localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8)
                                    ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] wdog_q;

    // Held at zero while idle so every access starts counting from zero in REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            wdog_q <= '0;
        end else if (state_q == ST_IDLE) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_q + CNT_W'(1);
        end
    end

    // A ready arriving in the final cycle still counts as completion.
    assign timeout = (state_q != ST_IDLE)
                     && (wdog_q == CNT_W'(TIMEOUT_CYCLES - 1))
                     && !((state_q == ST_ACCESS) && bus.bus_rdy);
`else
    // No watchdog: the parameter is only kept so both builds share one interface.
    assign timeout = (TIMEOUT_CYCLES == 0) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_c   = 1'b0;
        as_c    = 1'b0;
        rw_c    = 1'b0;
        busy_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    state_d = ST_REQ;
                    busy_c  = 1'b1;
                end
            end
            ST_REQ: begin
                req_c  = 1'b1;
                busy_c = !timeout;
                if (flush || timeout) begin
                    state_d = ST_IDLE;
                end else if (bus.bus_grnt) begin
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // Flush cannot abort a granted access; it lands once ready.
                req_c = 1'b1;
                as_c  = 1'b1;
                rw_c  = (ex_mem_op == MEM_OP_LDW);
                if (bus.bus_rdy || timeout) begin
                    state_d = ST_IDLE;
                end else begin
                    busy_c = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ME/WB register: reset/flush bubble, then bus error, misalign, normal pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_pc       <= '0;
            mem_en       <= 1'b0;
            mem_br_flag  <= 1'b0;
            mem_ctrl_op  <= '0;
            mem_dst_addr <= '0;
            mem_gpr_we_  <= 1'b1;
            mem_exp_code <= EXP_NO_EXP;
            mem_out      <= '0;
        end else if (!stall && !busy_c) begin
            if (flush) begin
                mem_pc       <= '0;
                mem_en       <= 1'b0;
                mem_br_flag  <= 1'b0;
                mem_ctrl_op  <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_NO_EXP;
                mem_out      <= '0;
            end else if (timeout) begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= '0;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_BUS_ERR;
                mem_out      <= '0;
            end else if (misalign) begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= '0;
                mem_dst_addr <= '0;
                mem_gpr_we_  <= 1'b1;
                mem_exp_code <= EXP_MISS_ALIGN;
                mem_out      <= '0;
            end else begin
                mem_pc       <= ex_pc;
                mem_en       <= ex_en;
                mem_br_flag  <= ex_br_flag;
                mem_ctrl_op  <= ex_ctrl_op;
                mem_dst_addr <= ex_dst_addr;
                mem_gpr_we_  <= ex_gpr_we_;
                mem_exp_code <= ex_exp_code;
                mem_out      <= (ex_mem_op == MEM_OP_LDW) ? bus.bus_rd_data : ex_out;
            end
        end
    end

endmodule
